// File: rtl/spwm_deadtime_gen.sv
// SPWM gate driver stage: regular-sampled carrier compare, complementary
// high/low gate pair with dead time, latched fault shutdown and a valley
// sync pulse for the sine table stepper.
// The modulating reference port is named ref_val because "ref" is a
// SystemVerilog keyword.
module spwm_deadtime_gen #(
    parameter int unsigned WIDTH       = 15,
    parameter int unsigned MOD_MAX     = 15358,
    parameter int unsigned DEAD_CYCLES = 50,
    parameter int unsigned DT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] carrier,
    input  logic [WIDTH-1:0] ref_val,
    input  logic             fault,
    input  logic             fault_clr,
    output logic             pwm_raw,
    output logic             gate_h,
    output logic             gate_l,
    output logic             sync,
    output logic             fault_lat
);

    localparam logic [WIDTH-1:0] ModMax   = WIDTH'(MOD_MAX);
    localparam logic [DT_W-1:0]  DeadLoad = DT_W'(DEAD_CYCLES - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StDead = 2'd1;
    localparam logic [1:0] StHigh = 2'd2;
    localparam logic [1:0] StLow  = 2'd3;

    logic [WIDTH-1:0] ref_q, ref_d, ref_clamped;
    logic [WIDTH-1:0] carrier_prev;
    logic [1:0]       state_q, state_d;
    logic             target_q, target_d;
    logic [DT_W-1:0]  cnt_q, cnt_d;
    logic             kill;

    // Reference latch: reload only at the carrier extremes so the compare
    // sees a constant reference across each half period.
    always_comb begin
        ref_clamped = (ref_val > ModMax) ? ModMax : ref_val;
        ref_d       = ref_q;
        if (carrier == '0 || carrier == ModMax) begin
            ref_d = ref_clamped;
        end
    end

    // Compare, valley detect and sticky fault flag
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_q        <= '0;
            pwm_raw      <= 1'b0;
            carrier_prev <= '0;
            sync         <= 1'b0;
            fault_lat    <= 1'b0;
        end else begin
            ref_q        <= ref_d;
            pwm_raw      <= (ref_d > carrier);
            carrier_prev <= carrier;
            sync         <= (carrier == '0) && (carrier_prev != '0);
            if (fault) begin
                fault_lat <= 1'b1;
            end else if (fault_clr) begin
                fault_lat <= 1'b0;
            end
        end
    end

    assign kill = fault | fault_lat | ~en;

    // Gate FSM next state; any pwm_raw change while in DEAD restarts the
    // dead band so short pulses are absorbed rather than shortening it.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        if (kill) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d  = StDead;
                    target_d = pwm_raw;
                    cnt_d    = DeadLoad;
                end
                StDead: begin
                    if (pwm_raw != target_q) begin
                        target_d = pwm_raw;
                        cnt_d    = DeadLoad;
                    end else if (cnt_q == '0) begin
                        state_d = target_q ? StHigh : StLow;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                StHigh: begin
                    if (!pwm_raw) begin
                        state_d  = StDead;
                        target_d = 1'b0;
                        cnt_d    = DeadLoad;
                    end
                end
                StLow: begin
                    if (pwm_raw) begin
                        state_d  = StDead;
                        target_d = 1'b1;
                        cnt_d    = DeadLoad;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Gate FSM state and registered gate decode from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            target_q <= 1'b0;
            cnt_q    <= '0;
            gate_h   <= 1'b0;
            gate_l   <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            gate_h   <= (state_d == StHigh);
            gate_l   <= (state_d == StLow);
        end
    end

endmodule

// File: tb/tb_spwm_deadtime_gen.sv
// Bench for spwm_deadtime_gen: random and directed stimulus against a
// run-length behavioural model of the gate pair.
module tb_spwm_deadtime_gen;

    localparam int MOD_MAX = 15358;
    localparam int DEAD    = 4;

    logic        clk = 1'b0;
    logic        rst, en, fault, fault_clr;
    logic [14:0] carrier, ref_val;
    logic        pwm_raw, gate_h, gate_l, sync, fault_lat;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Model state
    int m_refq, m_prev, run;
    bit m_pwm, m_sync, m_flat, run_val, m_gh, m_gl;

    spwm_deadtime_gen #(
        .WIDTH      (15),
        .MOD_MAX    (MOD_MAX),
        .DEAD_CYCLES(DEAD),
        .DT_W       (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .carrier  (carrier),
        .ref_val  (ref_val),
        .fault    (fault),
        .fault_clr(fault_clr),
        .pwm_raw  (pwm_raw),
        .gate_h   (gate_h),
        .gate_l   (gate_l),
        .sync     (sync),
        .fault_lat(fault_lat)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    // Advance one clock: model the edge from the current inputs, then compare.
    // The gates are modelled as "pwm_raw has held one value for more than DEAD
    // unkilled samples": run counts those samples, run_val is the held value.
    task automatic tick();
        bit kill;
        bit npwm, nsync, nflat;
        if (rst) begin
            m_refq = 0; m_prev = 0; run = 0; run_val = 0;
            m_pwm = 0; m_sync = 0; m_flat = 0; m_gh = 0; m_gl = 0;
        end else begin
            kill = fault || m_flat || !en;
            if (int'(carrier) == 0 || int'(carrier) == MOD_MAX)
                m_refq = (int'(ref_val) > MOD_MAX) ? MOD_MAX : int'(ref_val);
            npwm  = (m_refq > int'(carrier));
            nsync = (int'(carrier) == 0) && (m_prev != 0);
            m_prev = int'(carrier);
            nflat = fault ? 1'b1 : (fault_clr ? 1'b0 : m_flat);
            if (kill) begin
                run = 0;
            end else if (run == 0 || m_pwm != run_val) begin
                run = 1;
                run_val = m_pwm;
            end else if (run < 1000) begin
                run++;
            end
            m_gh = (run > DEAD) && run_val;
            m_gl = (run > DEAD) && !run_val;
            m_pwm = npwm; m_sync = nsync; m_flat = nflat;
        end
        @(posedge clk);
        #1;
        cyc++;
        check_eq("pwm_raw", 32'(pwm_raw), 32'(m_pwm));
        check_eq("gate_h", 32'(gate_h), 32'(m_gh));
        check_eq("gate_l", 32'(gate_l), 32'(m_gl));
        check_eq("sync", 32'(sync), 32'(m_sync));
        check_eq("fault_lat", 32'(fault_lat), 32'(m_flat));
        check_eq("no_overlap", 32'(gate_h & gate_l), 32'd0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    int cv, cdir, cstep;
    int k_cross, pwm_fall, gh_fall, gl_rise, sync_cnt;
    bit seen_h, prev_pwm, prev_gh, prev_gl;

    initial begin
        rst = 1; en = 0; fault = 0; fault_clr = 0; carrier = '0; ref_val = '0;
        ticks(3);
        check_eq("rst_pwm", 32'(pwm_raw), 32'd0);
        check_eq("rst_gates", 32'({gate_h, gate_l}), 32'd0);
        check_eq("rst_flat", 32'(fault_lat), 32'd0);
        rst = 0; en = 1;

        // Steady compare at ref=7679 with a unit-step ramp through the crossing
        carrier = '0; ref_val = 15'd7679; tick();
        k_cross = -1; pwm_fall = -1; gh_fall = -1; gl_rise = -1;
        for (int c = 7600; c < 7720; c++) begin
            prev_pwm = pwm_raw; prev_gh = gate_h; prev_gl = gate_l;
            carrier = 15'(c);
            if (c == 7679) k_cross = cyc + 1;
            tick();
            if (prev_pwm && !pwm_raw && pwm_fall < 0) pwm_fall = cyc;
            if (prev_gh && !gate_h && gh_fall < 0) gh_fall = cyc;
            if (!prev_gl && gate_l && gl_rise < 0) gl_rise = cyc;
        end
        check_eq("pwm_fall_lat", 32'(pwm_fall - k_cross), 32'd0);
        check_eq("gh_fall_lat", 32'(gh_fall - k_cross), 32'd1);
        check_eq("dead_band", 32'(gl_rise - gh_fall), 32'(DEAD));

        // Regular sampling: ref change mid ramp is ignored until the peak
        carrier = '0; ref_val = 15'd1000; tick();
        cv = 0;
        while (cv < MOD_MAX) begin
            cv = (cv + 50 > MOD_MAX) ? MOD_MAX : cv + 50;
            if (cv == 5000) ref_val = 15'd9000;
            carrier = 15'(cv);
            tick();
            if (cv == 8000) check_eq("hold_ref_up", 32'(pwm_raw), 32'd0);
        end
        while (cv > 0) begin
            cv = (cv < 50) ? 0 : cv - 50;
            carrier = 15'(cv);
            tick();
            if (cv == 8000) check_eq("new_ref_down", 32'(pwm_raw), 32'd1);
        end

        // Short pulse while in LOW is absorbed
        carrier = '0; ref_val = 15'd100; tick();
        carrier = 15'd200; ticks(10);
        check_eq("low_before_pulse", 32'(gate_l), 32'd1);
        seen_h = 0;
        carrier = 15'd50;
        for (int i = 0; i < 2; i++) begin tick(); seen_h |= gate_h; end
        carrier = 15'd200;
        for (int i = 0; i < 12; i++) begin tick(); seen_h |= gate_h; end
        check_eq("short_no_h", 32'(seen_h), 32'd0);
        check_eq("short_back_low", 32'(gate_l), 32'd1);

        // Fault latch, simultaneous clear, release through dead band
        fault = 1; tick(); fault = 0;
        check_eq("fault_gates", 32'({gate_h, gate_l}), 32'd0);
        ticks(3);
        check_eq("fault_sticky", 32'(fault_lat), 32'd1);
        fault = 1; fault_clr = 1; tick();
        check_eq("fault_wins", 32'(fault_lat), 32'd1);
        fault = 0; tick();
        check_eq("fault_cleared", 32'(fault_lat), 32'd0);
        fault_clr = 0;
        ticks(4);
        check_eq("release_dead", 32'(gate_l), 32'd0);
        tick();
        check_eq("release_low", 32'(gate_l), 32'd1);

        // Valley dwell gives one sync pulse
        sync_cnt = 0;
        carrier = 15'd30; tick();
        for (int i = 0; i < 5; i++) begin
            carrier = (i >= 1 && i <= 3) ? 15'd0 : 15'd20;
            tick();
            sync_cnt += int'(sync);
        end
        check_eq("sync_once", 32'(sync_cnt), 32'd1);

        // Clamp: oversized ref drives pwm high except at the peak
        carrier = '0; ref_val = 15'd20000; tick();
        carrier = 15'd15357; tick();
        check_eq("clamp_below_peak", 32'(pwm_raw), 32'd1);
        carrier = 15'(MOD_MAX); tick();
        check_eq("clamp_at_peak", 32'(pwm_raw), 32'd0);

        // Reset in the middle of HIGH
        carrier = 15'd100; ticks(8);
        check_eq("pre_rst_high", 32'(gate_h), 32'd1);
        rst = 1; tick(); rst = 0;
        check_eq("rst_mid_gates", 32'({gate_h, gate_l}), 32'd0);
        check_eq("rst_mid_pwm", 32'(pwm_raw), 32'd0);

        // Randomized triangle with random ref, enable, faults and resets
        cv = 0; cdir = 1; cstep = 200;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) ref_val = 15'($urandom_range(0, 20000));
            en        = ($urandom_range(0, 199) != 0);
            fault     = ($urandom_range(0, 299) == 0);
            fault_clr = ($urandom_range(0, 29) == 0);
            rst       = ($urandom_range(0, 999) == 0);
            if (cdir == 1) begin
                cv += cstep;
                if (cv >= MOD_MAX) begin cv = MOD_MAX; cdir = 0; end
            end else if (cv == 0 && $urandom_range(0, 3) == 0) begin
                cv = 0;  // dwell at the valley
            end else begin
                cv -= cstep;
                if (cv <= 0) begin
                    cv = 0; cdir = 1;
                    cstep = $urandom_range(40, 600);
                end
            end
            carrier = 15'(cv);
            tick();
        end
        rst = 0; fault = 0; fault_clr = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spwm_deadtime_gen.md
Name: spwm_deadtime_gen

Overview:
- Downstream stage of the SPWM carrier generator.
- Consumes the 15-bit triangular carrier `salida` (0 up to 15358 and back) and a 15-bit modulating reference (sine sample).
- Produces a regular-sampled PWM comparison plus a complementary high/low gate pair with programmable dead time, fault shutdown and a valley sync pulse for the sine table stepper.

Parameters:
- WIDTH, 15, carrier/reference bit width.
- MOD_MAX, 15358, carrier peak value; also the clamp for the reference.
- DEAD_CYCLES, 50, dead-time length in clk cycles; legal range 1..255.
- DT_W, 8, dead-time counter width.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  gate enable; 0 forces both gates off.
- carrier  input  WIDTH  triangle carrier from the SPWM counter stage.
- ref  input  WIDTH  modulating reference sample.
- fault  input  1  external fault; level-sensitive, latched.
- fault_clr  input  1  clears the latched fault.
- pwm_raw  output  1  registered comparison `ref_q > carrier`.
- gate_h  output  1  high-side gate.
- gate_l  output  1  low-side gate.
- sync  output  1  one-cycle pulse on carrier valley entry.
- fault_lat  output  1  sticky fault flag.

Behaviour:
- Reset: rst=1 at a clock edge sets the following; it applies mid-operation, so gates drop the cycle after rst is sampled.
  - ref_q=0, pwm_raw=0, gate_h=0, gate_l=0, sync=0, fault_lat=0.
  - carrier_prev=0, state=IDLE, dead counter=0.
- Reference latch (regular sampling):
  - ref_q loads min(ref, MOD_MAX) on any cycle where carrier==0 or carrier==MOD_MAX; otherwise it holds.
  - The latch is evaluated combinationally in the same cycle as the compare, so the new ref_q is used for the compare in that cycle.
- Compare stage: pwm_raw <= (ref_q_next > carrier), unsigned. Latency from carrier to pwm_raw is 1 cycle.
  - ref=0 gives pwm_raw constantly 0.
  - ref>=MOD_MAX gives pwm_raw=1 except when carrier==MOD_MAX.
- Sync: sync <= (carrier==0 && carrier_prev!=0).
  - Exactly one pulse per valley even when the carrier dwells at 0 for several cycles.
  - carrier_prev is a registered copy of carrier.
- Fault:
  - fault_lat <= 1 when fault=1.
  - Else fault_lat <= 0 when fault_clr=1.
  - fault=1 and fault_clr=1 together leave fault_lat=1 (fault wins).
- Gate FSM: evaluated on registered pwm_raw; gates are registered outputs decoded from the next state.
  - Force-off term: kill = fault | fault_lat | ~en.
  - IDLE: gate_h=0, gate_l=0. If !kill, go to DEAD with target=pwm_raw and counter=DEAD_CYCLES-1.
  - DEAD: both gates 0.
    - If pwm_raw != target: target=pwm_raw and the counter reloads to DEAD_CYCLES-1 (restart).
    - Else if counter==0: go to HIGH when target=1, LOW when target=0.
    - Else the counter decrements.
  - HIGH: gate_h=1, gate_l=0. If pwm_raw==0, go to DEAD with target=0 and counter reloaded.
  - LOW: gate_l=1, gate_h=0. If pwm_raw==1, go to DEAD with target=1 and counter reloaded.
  - kill=1 in any state: next state IDLE, both gates 0 the next cycle. kill has priority over every other transition.
- Gate timing:
  - Gate turn-off occurs 2 cycles after the carrier crossing.
  - Gate turn-on occurs 2+DEAD_CYCLES cycles after the crossing.
  - gate_h and gate_l are never 1 in the same cycle.
  - Every transition between them passes through at least DEAD_CYCLES cycles with both gates 0.
- Pulse handling: pulses shorter than DEAD_CYCLES are absorbed (no glitch, no shortened dead band).
- Arithmetic: all comparisons are unsigned. The counter never underflows, because reload and the zero check take precedence over decrement.

Test Plan (bench uses DEAD_CYCLES=4, MOD_MAX=15358):
- Reset mid-HIGH: assert rst for 1 cycle while gate_h=1 -> next cycle gate_h=0, gate_l=0, fault_lat=0, pwm_raw=0, state IDLE.
- Steady compare:
  - Stimulus: ref=7679 presented at carrier valley, carrier ramping by 1 per cycle.
  - pwm_raw falls 1 cycle after carrier reaches 7679.
  - gate_h falls 2 cycles after that crossing.
  - gate_l rises exactly 4 cycles after gate_h falls.
  - Both gates are never high together.
- Regular sampling: change ref from 1000 to 9000 mid-ramp (carrier=5000) -> ref_q and pwm_raw unchanged until carrier hits 0 or 15358; 9000 is used from that cycle.
- Short pulse: pwm_raw high for 2 cycles while in LOW -> DEAD, target flips back, counter restarts, returns to LOW after 4 cycles; gate_h never asserts.
- Fault:
  - fault=1 for 1 cycle while gate_l=1 -> both gates 0 next cycle; fault_lat=1 persists.
  - fault_clr=1 -> fault_lat=0, then DEAD for 4 cycles, then the gate matching pwm_raw.
  - fault and fault_clr together -> fault_lat stays 1.
- Sync and clamp:
  - Carrier dwelling 3 cycles at 0 -> a single sync pulse.
  - ref=20000 -> ref_q=15358 and pwm_raw=1 for all carrier values except 15358.
